// File: rtl/rv32_mc_sequencer_if.sv
// Shared instruction/data memory handshake between the femtoRV32 sequencer and the memory port.
interface rv32_mc_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ack
  );
endinterface

// File: rtl/rv32_mc_sequencer.sv
// Multi-cycle control FSM for femtoRV32: fetch/decode/exec/mem/wb over one shared memory port.
// Optional macro RV32_SYSTEM_HALT_EN makes ECALL/EBREAK halt the core cleanly (err stays 0).
module rv32_mc_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  rv32_mc_sequencer_if.master        mem,
  input  logic [31:0]                ir,
  input  logic                       br_taken,
  output logic                       ir_we,
  output logic                       pc_we,
  output logic [1:0]                 pc_src,
  output logic                       reg_we,
  output logic [1:0]                 wb_sel,
  output logic                       alu_a_sel,
  output logic                       alu_b_sel,
  output logic [2:0]                 state,
  output logic                       halted,
  output logic                       err
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    OpArithR,
    OpArithI,
    OpLui,
    OpAuipc,
    OpJal,
    OpJalr,
    OpBranch,
    OpLoad,
    OpStore,
    OpFence,
    OpSystem,
    OpIllegal
  } op_e;

  localparam int unsigned    CntW   = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT - 1);
  localparam bit             WdEn   = (MEM_TIMEOUT != 0);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  op_e             op;

  logic       mem_req_c, mem_we_c, mem_addr_sel_c;
  logic       ir_we_c, pc_we_c, reg_we_c, alu_a_sel_c, alu_b_sel_c, halted_c;
  logic [1:0] pc_src_c, wb_sel_c;
  logic       wd_expire;

  // Only the opcode field steers control; the rest of ir belongs to the datapath.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[31:7];

  always_comb begin
    op = OpIllegal;
    unique case (ir[6:0])
      7'b0110011: op = OpArithR;
      7'b0010011: op = OpArithI;
      7'b0110111: op = OpLui;
      7'b0010111: op = OpAuipc;
      7'b1101111: op = OpJal;
      7'b1100111: op = OpJalr;
      7'b1100011: op = OpBranch;
      7'b0000011: op = OpLoad;
      7'b0100011: op = OpStore;
      7'b0001111: op = OpFence;
      7'b1110011: op = OpSystem;
      default:    op = OpIllegal;
    endcase
  end

  assign wd_expire = WdEn && (cnt_q == CntMax);

  always_comb begin
    state_d        = state_q;
    err_d          = err_q;
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_sel_c = 1'b0;
    ir_we_c        = 1'b0;
    pc_we_c        = 1'b0;
    pc_src_c       = 2'd0;
    reg_we_c       = 1'b0;
    wb_sel_c       = 2'd0;
    alu_a_sel_c    = 1'b0;
    alu_b_sel_c    = 1'b0;
    halted_c       = 1'b0;

    case (state_q)
      StFetch: begin
        mem_req_c = 1'b1;
        if (mem.mem_ack) begin
          ir_we_c = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (op == OpIllegal) begin
          err_d   = 1'b1;
          state_d = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        pc_we_c = 1'b1;
        state_d = StFetch;
        case (op)
          OpArithR: reg_we_c = 1'b1;
          OpArithI: begin
            alu_b_sel_c = 1'b1;
            reg_we_c    = 1'b1;
          end
          OpLui: begin
            reg_we_c = 1'b1;
            wb_sel_c = 2'd3;
          end
          OpAuipc: begin
            alu_a_sel_c = 1'b1;
            alu_b_sel_c = 1'b1;
            reg_we_c    = 1'b1;
          end
          OpJal: begin
            pc_src_c = 2'd1;
            reg_we_c = 1'b1;
            wb_sel_c = 2'd2;
          end
          OpJalr: begin
            alu_b_sel_c = 1'b1;
            pc_src_c    = 2'd2;
            reg_we_c    = 1'b1;
            wb_sel_c    = 2'd2;
          end
          OpBranch: pc_src_c = br_taken ? 2'd1 : 2'd0;
          OpLoad, OpStore: begin
            alu_b_sel_c = 1'b1;
            pc_we_c     = 1'b0;
            state_d     = StMem;
          end
          OpSystem: begin
`ifdef RV32_SYSTEM_HALT_EN
            pc_we_c = 1'b0;
            state_d = StHalt;
`endif
          end
          default: ;
        endcase
      end
      StMem: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = 1'b1;
        alu_b_sel_c    = 1'b1;
        mem_we_c       = (op == OpStore);
        if (mem.mem_ack) begin
          if (op == OpStore) begin
            pc_we_c = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        reg_we_c = 1'b1;
        wb_sel_c = 2'd1;
        pc_we_c  = 1'b1;
        state_d  = StFetch;
      end
      StHalt: halted_c = 1'b1;
      default: state_d = StFetch;
    endcase

    // An ack on the final allowed cycle wins over the timeout.
    if (mem_req_c && !mem.mem_ack && wd_expire) begin
      err_d   = 1'b1;
      state_d = StHalt;
    end
  end

  always_comb begin
    cnt_d = '0;
    if (WdEn && mem_req_c && !mem.mem_ack && (state_d == state_q)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Every output is forced low while rst is held.
  always_comb begin
    mem.mem_req      = mem_req_c & ~rst;
    mem.mem_we       = mem_we_c & ~rst;
    mem.mem_addr_sel = mem_addr_sel_c & ~rst;
    ir_we            = ir_we_c & ~rst;
    pc_we            = pc_we_c & ~rst;
    pc_src           = rst ? 2'd0 : pc_src_c;
    reg_we           = reg_we_c & ~rst;
    wb_sel           = rst ? 2'd0 : wb_sel_c;
    alu_a_sel        = alu_a_sel_c & ~rst;
    alu_b_sel        = alu_b_sel_c & ~rst;
    state            = rst ? 3'd0 : state_q;
    halted           = halted_c & ~rst;
    err              = err_q & ~rst;
  end

endmodule

// File: tb/tb_rv32_mc_sequencer.sv
// Directed self-checking bench for rv32_mc_sequencer (MEM_TIMEOUT=4).
module tb_rv32_mc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir;
  logic        br_taken;
  logic        ir_we, pc_we, reg_we, alu_a_sel, alu_b_sel, halted, err;
  logic [1:0]  pc_src, wb_sel;
  logic [2:0]  state;

  rv32_mc_sequencer_if mem_if ();

  rv32_mc_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem       (mem_if),
    .ir        (ir),
    .br_taken  (br_taken),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .state     (state),
    .halted    (halted),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] ctl;
  assign ctl = {state, mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr_sel, ir_we, pc_we,
                pc_src, reg_we, wb_sel, alu_a_sel, alu_b_sel, halted, err};

  localparam logic [31:0] ADDI  = 32'h0050_0093;
  localparam logic [31:0] LW    = 32'h0000_A103;
  localparam logic [31:0] SW    = 32'h0020_A023;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  function automatic logic [16:0] ex(int st, int req, int mwe, int masel, int irwe, int pcwe,
                                     int pcsrc, int regwe, int wbsel, int asel, int bsel,
                                     int hlt, int er);
    logic [2:0] s;
    logic [1:0] p, w;
    s = st[2:0];
    p = pcsrc[1:0];
    w = wbsel[1:0];
    return {s, req[0], mwe[0], masel[0], irwe[0], pcwe[0], p, regwe[0], w, asel[0], bsel[0],
            hlt[0], er[0]};
  endfunction

  logic [16:0] e_fetch_ack, e_fetch_wait, e_decode, e_halt_err;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_if.mem_ack = 1'b1;
    ir = 32'h0;
    br_taken = 1'b0;
    step();
    #1;
    n_tests++;
    if (ctl !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_hold ctl=%h expected=%h", ctl, 17'h0);
    end
    step();
    #1;
    n_tests++;
    if (ctl !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_hold2 ctl=%h expected=%h", ctl, 17'h0);
    end
    mem_if.mem_ack = 1'b0;
    rst = 1'b0;
    #1;
    n_tests++;
    if (ctl !== e_fetch_wait) begin
      n_fail++;
      $display("FAIL reset_release ctl=%h expected=%h", ctl, e_fetch_wait);
    end
  endtask

  task automatic test_addi();
    logic [16:0] exp_seq [4];
    exp_seq[0] = e_fetch_ack;
    exp_seq[1] = e_decode;
    exp_seq[2] = ex(2, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0);
    exp_seq[3] = e_fetch_ack;
    ir = ADDI;
    mem_if.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step();
      #1;
      n_tests++;
      if (ctl !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL addi_cycle%0d ctl=%h expected=%h", i, ctl, exp_seq[i]);
      end
    end
  endtask

  task automatic test_load_wait();
    logic [16:0] exp_seq [8];
    logic        ack_seq [8];
    exp_seq[0] = e_fetch_wait;  ack_seq[0] = 1'b0;
    exp_seq[1] = e_fetch_wait;  ack_seq[1] = 1'b0;
    exp_seq[2] = e_fetch_ack;   ack_seq[2] = 1'b1;
    exp_seq[3] = e_decode;      ack_seq[3] = 1'b1;
    exp_seq[4] = ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);  ack_seq[4] = 1'b1;
    exp_seq[5] = ex(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);  ack_seq[5] = 1'b1;
    exp_seq[6] = ex(4, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);  ack_seq[6] = 1'b1;
    exp_seq[7] = e_fetch_ack;   ack_seq[7] = 1'b1;
    ir = LW;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) step();
      mem_if.mem_ack = ack_seq[i];
      #1;
      n_tests++;
      if (ctl !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL load_cycle%0d ctl=%h expected=%h", i, ctl, exp_seq[i]);
      end
    end
  endtask

  task automatic test_store();
    ir = SW;
    mem_if.mem_ack = 1'b1;
    step();
    step();
    #1;
    n_tests++;
    if (ctl !== ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)) begin
      n_fail++;
      $display("FAIL store_exec ctl=%h", ctl);
    end
    step();
    mem_if.mem_ack = 1'b0;
    #1;
    n_tests++;
    if (ctl !== ex(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0)) begin
      n_fail++;
      $display("FAIL store_mem_wait ctl=%h", ctl);
    end
    step();
    mem_if.mem_ack = 1'b1;
    #1;
    n_tests++;
    if (ctl !== ex(3, 1, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0)) begin
      n_fail++;
      $display("FAIL store_mem_ack ctl=%h", ctl);
    end
    step();
    #1;
    n_tests++;
    if (ctl !== e_fetch_ack) begin
      n_fail++;
      $display("FAIL store_return ctl=%h expected=%h", ctl, e_fetch_ack);
    end
  endtask

  task automatic test_exec_ops();
    logic [31:0] vi [8];
    logic        vb [8];
    logic [16:0] ve [8];
    vi[0] = 32'h0020_81B3; vb[0] = 1'b0; ve[0] = ex(2, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    vi[1] = 32'h0020_8463; vb[1] = 1'b1; ve[1] = ex(2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    vi[2] = 32'h0020_8463; vb[2] = 1'b0; ve[2] = ex(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    vi[3] = 32'h0000_80E7; vb[3] = 1'b0; ve[3] = ex(2, 0, 0, 0, 0, 1, 2, 1, 2, 0, 1, 0, 0);
    vi[4] = 32'h0080_006F; vb[4] = 1'b0; ve[4] = ex(2, 0, 0, 0, 0, 1, 1, 1, 2, 0, 0, 0, 0);
    vi[5] = 32'h1234_50B7; vb[5] = 1'b0; ve[5] = ex(2, 0, 0, 0, 0, 1, 0, 1, 3, 0, 0, 0, 0);
    vi[6] = 32'h0000_0097; vb[6] = 1'b0; ve[6] = ex(2, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0);
    vi[7] = 32'h0FF0_000F; vb[7] = 1'b0; ve[7] = ex(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    mem_if.mem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ir = vi[i];
      br_taken = vb[i];
      step();
      step();
      #1;
      n_tests++;
      if (ctl !== ve[i]) begin
        n_fail++;
        $display("FAIL exec_op%0d ir=%h ctl=%h expected=%h", i, vi[i], ctl, ve[i]);
      end
      step();
      #1;
      n_tests++;
      if (state !== 3'd0) begin
        n_fail++;
        $display("FAIL exec_op%0d_return state=%0d expected=0", i, state);
      end
    end
    br_taken = 1'b0;
  endtask

  task automatic test_illegal();
    ir = 32'h0;
    mem_if.mem_ack = 1'b1;
    step();
    #1;
    n_tests++;
    if (ctl !== e_decode) begin
      n_fail++;
      $display("FAIL illegal_decode ctl=%h expected=%h", ctl, e_decode);
    end
    step();
    #1;
    n_tests++;
    if (ctl !== e_halt_err) begin
      n_fail++;
      $display("FAIL illegal_halt ctl=%h expected=%h", ctl, e_halt_err);
    end
    step();
    #1;
    n_tests++;
    if (ctl !== e_halt_err) begin
      n_fail++;
      $display("FAIL illegal_halt_stays ctl=%h expected=%h", ctl, e_halt_err);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (ctl !== 17'h0) begin
      n_fail++;
      $display("FAIL illegal_rst_outputs ctl=%h expected=0", ctl);
    end
    step();
    rst = 1'b0;
    mem_if.mem_ack = 1'b0;
    #1;
    n_tests++;
    if (ctl !== e_fetch_wait) begin
      n_fail++;
      $display("FAIL illegal_rst_recover ctl=%h expected=%h", ctl, e_fetch_wait);
    end
    // addi opcode with ir[1:0] != 2'b11 must also be rejected
    ir = 32'h0000_0012;
    mem_if.mem_ack = 1'b1;
    step();
    step();
    #1;
    n_tests++;
    if (ctl !== e_halt_err) begin
      n_fail++;
      $display("FAIL illegal_lowbits ctl=%h expected=%h", ctl, e_halt_err);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_if.mem_ack = 1'b0;
    #1;
  endtask

  task automatic test_timeout();
    ir = ADDI;
    mem_if.mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step();
      #1;
      n_tests++;
      if (ctl !== e_fetch_wait) begin
        n_fail++;
        $display("FAIL timeout_wait%0d ctl=%h expected=%h", i, ctl, e_fetch_wait);
      end
    end
    step();
    #1;
    n_tests++;
    if (ctl !== e_halt_err) begin
      n_fail++;
      $display("FAIL timeout_halt ctl=%h expected=%h", ctl, e_halt_err);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_if.mem_ack = 1'b0;
    step();
    step();
    step();
    mem_if.mem_ack = 1'b1;
    #1;
    n_tests++;
    if (ctl !== e_fetch_ack) begin
      n_fail++;
      $display("FAIL timeout_late_ack ctl=%h expected=%h", ctl, e_fetch_ack);
    end
    step();
    #1;
    n_tests++;
    if (ctl !== e_decode) begin
      n_fail++;
      $display("FAIL timeout_late_ack_decode ctl=%h expected=%h", ctl, e_decode);
    end
    step();
    step();
  endtask

  task automatic test_reset_mid_access();
    ir = LW;
    mem_if.mem_ack = 1'b1;
    step();
    step();
    step();
    mem_if.mem_ack = 1'b0;
    #1;
    n_tests++;
    if (state !== 3'd3) begin
      n_fail++;
      $display("FAIL midreset_in_mem state=%0d expected=3", state);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_tests++;
    if (ctl !== e_fetch_wait) begin
      n_fail++;
      $display("FAIL midreset_refetch ctl=%h expected=%h", ctl, e_fetch_wait);
    end
  endtask

  task automatic test_system();
    ir = ECALL;
    mem_if.mem_ack = 1'b1;
    step();
    step();
    #1;
`ifdef RV32_SYSTEM_HALT_EN
    n_tests++;
    if (ctl !== ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL ecall_exec ctl=%h", ctl);
    end
    step();
    #1;
    n_tests++;
    if (ctl !== ex(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)) begin
      n_fail++;
      $display("FAIL ecall_halt ctl=%h", ctl);
    end
`else
    n_tests++;
    if (ctl !== ex(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL ecall_exec ctl=%h", ctl);
    end
    step();
    #1;
    n_tests++;
    if (ctl !== e_fetch_ack) begin
      n_fail++;
      $display("FAIL ecall_return ctl=%h expected=%h", ctl, e_fetch_ack);
    end
`endif
  endtask

  initial begin
    e_fetch_ack  = ex(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    e_fetch_wait = ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_decode     = ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_halt_err   = ex(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    test_reset();
    test_addi();
    test_load_wait();
    test_store();
    test_exec_ops();
    test_illegal();
    test_timeout();
    test_reset_mid_access();
    test_system();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
